// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-control bundle shared between the two
// requesters, the arbiter and the external 16-bit ALU.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_half;
  logic        req0_byte;

  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_half;
  logic        req1_byte;

  logic        rsp_valid;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_cout;
  logic        rsp_z;
  logic        rsp_err;

  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_subtract;
  logic        alu_mult;
  logic        alu_and;
  logic        alu_or;
  logic        alu_xor;
  logic        alu_not;
  logic        alu_lshift;
  logic        alu_rshift;
  logic        alu_half;
  logic        alu_byte;
  logic [15:0] alu_sum;
  logic        alu_cout;
  logic        alu_z;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_half, req0_byte,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, req1_half, req1_byte,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_z, rsp_err,
    output alu_a, alu_b, alu_subtract, alu_mult, alu_and, alu_or,
           alu_xor, alu_not, alu_lshift, alu_rshift, alu_half, alu_byte,
    input  alu_sum, alu_cout, alu_z
  );

  // Requesters plus ALU side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_half, req0_byte,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b, req1_half, req1_byte,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_z, rsp_err,
    input  alu_a, alu_b, alu_subtract, alu_mult, alu_and, alu_or,
           alu_xor, alu_not, alu_lshift, alu_rshift, alu_half, alu_byte,
    output alu_sum, alu_cout, alu_z
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit ALU between the CPU
// core (port 0) and the coprocessor/DMA side (port 1). Accepts one op in
// IDLE, drives the ALU strobes for the execute window, then pulses a
// one-cycle tagged response.
module alu_arbiter #(
  parameter int unsigned MULT_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MULT = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_NOT  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8
  } op_t;

  localparam logic [2:0] MULT_LOAD = 3'(MULT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        last_grant;
  logic        grant;
  logic        hs;
  logic [2:0]  cnt;

  logic [3:0]  sel_op;
  logic [15:0] sel_a, sel_b;
  logic        sel_half, sel_byte;

  logic [3:0]  op_q;
  logic [15:0] a_q, b_q;
  logic        half_q, byte_q, id_q;
  logic        op_illegal;

  logic [15:0] res_q;
  logic        cout_q, z_q, err_q;

  // Round-robin grant: a lone requester always wins, a tie goes to the
  // port that did not win last time.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else if (bus.req1_valid)              grant = 1'b1;
  end

  assign bus.req0_ready = (state == IDLE) && !grant && bus.req0_valid;
  assign bus.req1_ready = (state == IDLE) &&  grant && bus.req1_valid;
  assign hs             = bus.req0_ready || bus.req1_ready;

  // Payload of the winning port
  always_comb begin
    sel_op   = grant ? bus.req1_op   : bus.req0_op;
    sel_a    = grant ? bus.req1_a    : bus.req0_a;
    sel_b    = grant ? bus.req1_b    : bus.req0_b;
    sel_half = grant ? bus.req1_half : bus.req0_half;
    sel_byte = grant ? bus.req1_byte : bus.req0_byte;
  end

  assign op_illegal = (op_q > 4'(OP_SHR));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    if (cnt == 3'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, execute counter, grant history and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      cnt        <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      half_q     <= 1'b0;
      byte_q     <= 1'b0;
      id_q       <= 1'b0;
      res_q      <= '0;
      cout_q     <= 1'b0;
      z_q        <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (hs) begin
        last_grant <= grant;
        op_q       <= sel_op;
        a_q        <= sel_a;
        b_q        <= sel_b;
        half_q     <= sel_half;
        byte_q     <= sel_byte;
        id_q       <= grant;
        cnt        <= (sel_op == 4'(OP_MULT)) ? MULT_LOAD : 3'd0;
      end
      if (state == EXEC) begin
        if (cnt != 3'd0) begin
          cnt <= cnt - 3'd1;
        end else if (op_illegal) begin
          res_q  <= '0;
          cout_q <= 1'b0;
          z_q    <= 1'b0;
          err_q  <= 1'b1;
        end else begin
          res_q  <= bus.alu_sum;
          cout_q <= bus.alu_cout;
          z_q    <= bus.alu_z;
          err_q  <= 1'b0;
        end
      end
    end
  end

  // ALU drive: latched operands and one-hot strobe during EXEC only
  always_comb begin
    bus.alu_a        = '0;
    bus.alu_b        = '0;
    bus.alu_half     = 1'b0;
    bus.alu_byte     = 1'b0;
    bus.alu_subtract = 1'b0;
    bus.alu_mult     = 1'b0;
    bus.alu_and      = 1'b0;
    bus.alu_or       = 1'b0;
    bus.alu_xor      = 1'b0;
    bus.alu_not      = 1'b0;
    bus.alu_lshift   = 1'b0;
    bus.alu_rshift   = 1'b0;
    if (state == EXEC) begin
      bus.alu_a    = a_q;
      bus.alu_b    = b_q;
      bus.alu_half = half_q;
      bus.alu_byte = byte_q;
      case (op_q)
        OP_SUB:  bus.alu_subtract = 1'b1;
        OP_MULT: bus.alu_mult     = 1'b1;
        OP_AND:  bus.alu_and      = 1'b1;
        OP_OR:   bus.alu_or       = 1'b1;
        OP_XOR:  bus.alu_xor      = 1'b1;
        OP_NOT:  bus.alu_not      = 1'b1;
        OP_SHL:  bus.alu_lshift   = 1'b1;
        OP_SHR:  bus.alu_rshift   = 1'b1;
        default: ;
      endcase
    end
  end

  // Response outputs
  always_comb begin
    bus.rsp_valid  = (state == RESP);
    bus.rsp_id     = id_q;
    bus.rsp_result = res_q;
    bus.rsp_cout   = cout_q;
    bus.rsp_z      = z_q;
    bus.rsp_err    = err_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the external ALU from the strobes, predicts
// each accepted op into a scoreboard queue and checks every response.
module tb_alu_arbiter;

  localparam int unsigned MC = 2;

  typedef struct packed {
    logic        id;
    logic [15:0] result;
    logic        cout;
    logic        z;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  rsp_t exp_q[$];

  alu_arbiter_if bus();

  alu_arbiter #(.MULT_CYCLES(MC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference behaviour of one op, expressed by opcode
  function automatic rsp_t ref_op(input logic id, input logic [3:0] op,
                                  input logic [15:0] a, input logic [15:0] b,
                                  input logic half, input logic bm);
    logic [31:0] full;
    logic [15:0] ain, bin, sum;
    rsp_t r;
    ain = bm ? {15'b0, |a} : a;
    bin = bm ? {15'b0, |b} : b;
    if (half) begin
      ain = {8'b0, ain[7:0]};
      bin = {8'b0, bin[7:0]};
    end
    full = '0;
    r.id = id;
    r.err = 1'b0;
    case (op)
      4'd0: full = {16'b0, ain} + {16'b0, bin};
      4'd1: full = {16'b0, ain} - {16'b0, bin};
      4'd2: full = {16'b0, ain} * {16'b0, bin};
      4'd3: full = {16'b0, ain & bin};
      4'd4: full = {16'b0, ain | bin};
      4'd5: full = {16'b0, ain ^ bin};
      4'd6: full = {16'b0, ~ain};
      4'd7: full = {16'b0, ain} << 1;
      4'd8: full = {16'b0, ain} >> 1;
      default: r.err = 1'b1;
    endcase
    if (r.err) begin
      r.result = '0;
      r.cout   = 1'b0;
      r.z      = 1'b0;
    end else begin
      sum      = half ? {8'b0, full[7:0]} : full[15:0];
      r.result = sum;
      r.cout   = half ? full[8] : full[16];
      r.z      = (sum == 16'h0000);
    end
    return r;
  endfunction

  // External ALU: decodes the strobes back to an op; multiple strobes give garbage
  logic [7:0] strobes;
  logic [3:0] alu_op;
  rsp_t       alu_r;
  assign strobes = {bus.alu_subtract, bus.alu_mult, bus.alu_and, bus.alu_or,
                    bus.alu_xor, bus.alu_not, bus.alu_lshift, bus.alu_rshift};

  always_comb begin
    alu_op = 4'd0;
    if (bus.alu_subtract) alu_op = 4'd1;
    if (bus.alu_mult)     alu_op = 4'd2;
    if (bus.alu_and)      alu_op = 4'd3;
    if (bus.alu_or)       alu_op = 4'd4;
    if (bus.alu_xor)      alu_op = 4'd5;
    if (bus.alu_not)      alu_op = 4'd6;
    if (bus.alu_lshift)   alu_op = 4'd7;
    if (bus.alu_rshift)   alu_op = 4'd8;
    alu_r = ref_op(1'b0, alu_op, bus.alu_a, bus.alu_b, bus.alu_half, bus.alu_byte);
    if ($countones(strobes) > 1) begin
      bus.alu_sum  = 16'hBAD0;
      bus.alu_cout = 1'b1;
      bus.alu_z    = 1'b1;
    end else begin
      bus.alu_sum  = alu_r.result;
      bus.alu_cout = alu_r.cout;
      bus.alu_z    = alu_r.z;
    end
  end

  // Scoreboard push on every observed handshake
  always @(negedge clk) begin
    if (bus.req0_ready) begin
      exp_q.push_back(ref_op(1'b0, bus.req0_op, bus.req0_a, bus.req0_b, bus.req0_half, bus.req0_byte));
      hs_cyc = cyc;
    end
    if (bus.req1_ready) begin
      exp_q.push_back(ref_op(1'b1, bus.req1_op, bus.req1_a, bus.req1_b, bus.req1_half, bus.req1_byte));
      hs_cyc = cyc;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Present one request, wait (bounded) for its ready, then drop valid
  task automatic issue(input bit port, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic half, input logic bm,
                       output bit ok);
    @(posedge clk); #1;
    if (!port) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      bus.req0_half = half; bus.req0_byte = bm;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      bus.req1_half = half; bus.req1_byte = bm;
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (port ? bus.req1_ready : bus.req0_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    if (!port) bus.req0_valid = 1'b0;
    else       bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1'b1;
    end
  endtask

  function automatic rsp_t act_rsp();
    return {bus.rsp_id, bus.rsp_result, bus.rsp_cout, bus.rsp_z, bus.rsp_err};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_cout, bus.rsp_z, bus.rsp_err} !== 21'd0) begin
      n_fail++; $display("FAIL reset_rsp: got %h want 0", {bus.rsp_valid, bus.rsp_result});
    end
    n_tests++;
    if ({bus.alu_a, bus.alu_b, strobes, bus.alu_half, bus.alu_byte} !== 42'd0) begin
      n_fail++; $display("FAIL reset_alu: a=%h b=%h strobes=%b", bus.alu_a, bus.alu_b, strobes);
    end
    n_tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b want 00", {bus.req0_ready, bus.req1_ready});
    end
    do_reset();
  endtask

  task automatic test_add();
    bit ok, got;
    rsp_t e;
    issue(1'b0, 4'd0, 16'h0003, 16'h0004, 1'b0, 1'b0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL add_ready: got 0 want 1"); end
    @(negedge clk);
    n_tests++;
    if (bus.alu_a !== 16'h0003 || strobes !== 8'h00) begin
      n_fail++; $display("FAIL add_exec: alu_a=%h strobes=%b want 0003/00000000", bus.alu_a, strobes);
    end
    wait_rsp(got);
    n_tests++;
    if (!got || exp_q.size() == 0) begin
      n_fail++; $display("FAIL add_rsp: got no response, want one (queued=%0d)", exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (act_rsp() !== e) begin n_fail++; $display("FAIL add_rsp: got %h want %h", act_rsp(), e); end
    end
    n_tests++;
    if (cyc - hs_cyc != 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", cyc - hs_cyc); end
    @(negedge clk);
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_pulse: rsp_valid got 1 want 0"); end
  endtask

  task automatic test_back_to_back();
    bit got;
    rsp_t e;
    int prev;
    do_reset();
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_op = 4'd1; bus.req0_a = 16'd5; bus.req0_b = 16'd5;
    bus.req0_half = 1'b0; bus.req0_byte = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 4'd1; bus.req1_a = 16'd5; bus.req1_b = 16'd5;
    bus.req1_half = 1'b0; bus.req1_byte = 1'b0;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(got);
      n_tests++;
      if (!got || exp_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_rsp%0d: got no response, want one", i);
      end else begin
        e = exp_q.pop_front();
        if (act_rsp() !== e || bus.rsp_id !== 1'(i % 2) || bus.rsp_z !== 1'b1 || bus.rsp_result !== 16'h0000) begin
          n_fail++; $display("FAIL b2b_rsp%0d: got %h want %h id %0d", i, act_rsp(), e, i % 2);
        end
        if (i > 0) begin
          n_tests++;
          if (cyc - prev != 3) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want 3", i, cyc - prev); end
        end
        prev = cyc;
      end
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_mult();
    bit ok, got;
    rsp_t e;
    int mcnt;
    issue(1'b1, 4'd2, 16'h0100, 16'h0100, 1'b0, 1'b0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL mult_ready: got 0 want 1"); end
    mcnt = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1'b1;
      else if (bus.alu_mult) mcnt++;
    end
    n_tests++;
    if (mcnt != int'(MC)) begin n_fail++; $display("FAIL mult_window: got %0d want %0d", mcnt, MC); end
    n_tests++;
    if (cyc - hs_cyc != int'(MC) + 1) begin
      n_fail++; $display("FAIL mult_latency: got %0d want %0d", cyc - hs_cyc, MC + 1);
    end
    n_tests++;
    if (!got || exp_q.size() == 0) begin
      n_fail++; $display("FAIL mult_rsp: got no response, want one");
    end else begin
      e = exp_q.pop_front();
      if (act_rsp() !== e || bus.rsp_cout !== 1'b1 || bus.rsp_result !== 16'h0000) begin
        n_fail++; $display("FAIL mult_rsp: got %h want %h", act_rsp(), e);
      end
    end
  endtask

  task automatic test_illegal();
    bit ok, got;
    rsp_t e;
    issue(1'b0, 4'hC, 16'h1234, 16'h4321, 1'b0, 1'b0, ok);
    @(negedge clk);
    n_tests++;
    if (!ok || strobes !== 8'h00) begin
      n_fail++; $display("FAIL illegal_strobes: ready=%0b strobes=%b want 1/00000000", ok, strobes);
    end
    wait_rsp(got);
    n_tests++;
    if (!got || exp_q.size() == 0) begin
      n_fail++; $display("FAIL illegal_rsp: got no response, want one");
    end else begin
      e = exp_q.pop_front();
      if (act_rsp() !== e || bus.rsp_err !== 1'b1) begin
        n_fail++; $display("FAIL illegal_rsp: got %h want %h", act_rsp(), e);
      end
    end
    issue(1'b0, 4'd5, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, ok);
    wait_rsp(got);
    n_tests++;
    if (!got || exp_q.size() == 0) begin
      n_fail++; $display("FAIL after_illegal: got no response, want one");
    end else begin
      e = exp_q.pop_front();
      if (act_rsp() !== e || bus.rsp_err !== 1'b0) begin
        n_fail++; $display("FAIL after_illegal: got %h want %h", act_rsp(), e);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    bit ok, got;
    rsp_t e;
    int seen;
    issue(1'b0, 4'd2, 16'd7, 16'd9, 1'b0, 1'b0, ok);
    @(negedge clk);
    n_tests++;
    if (bus.alu_mult !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: alu_mult got %b want 1", bus.alu_mult); end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.alu_a, bus.alu_b, strobes, bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 43'd0) begin
      n_fail++; $display("FAIL midrst_outputs: a=%h strobes=%b rsp_valid=%b want 0", bus.alu_a, strobes, bus.rsp_valid);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL midrst_dropped: got %0d pulses want 0", seen); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_op = 4'd0; bus.req0_a = 16'h1111; bus.req0_b = 16'h2222;
    bus.req0_half = 1'b0; bus.req0_byte = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 4'd0; bus.req1_a = 16'h5555; bus.req1_b = 16'h0001;
    bus.req1_half = 1'b0; bus.req1_byte = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL midrst_priority: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_rsp(got);
    n_tests++;
    if (!got || exp_q.size() == 0) begin
      n_fail++; $display("FAIL midrst_rsp: got no response, want one");
    end else begin
      e = exp_q.pop_front();
      if (act_rsp() !== e || bus.rsp_result !== 16'h3333) begin
        n_fail++; $display("FAIL midrst_rsp: got %h want %h", act_rsp(), e);
      end
    end
  endtask

  task automatic test_shl_half();
    bit ok, got;
    rsp_t e;
    issue(1'b0, 4'd7, 16'h8001, 16'h0000, 1'b1, 1'b0, ok);
    @(negedge clk);
    n_tests++;
    if (!ok || bus.alu_lshift !== 1'b1 || bus.alu_half !== 1'b1) begin
      n_fail++; $display("FAIL shl_exec: lshift=%b half=%b want 1/1", bus.alu_lshift, bus.alu_half);
    end
    wait_rsp(got);
    n_tests++;
    if (!got || exp_q.size() == 0) begin
      n_fail++; $display("FAIL shl_rsp: got no response, want one");
    end else begin
      e = exp_q.pop_front();
      if (act_rsp() !== e || bus.rsp_result !== 16'h0002 || bus.rsp_cout !== 1'b0) begin
        n_fail++; $display("FAIL shl_rsp: got %h want %h", act_rsp(), e);
      end
    end
  endtask

  task automatic test_all_ops();
    bit ok, got;
    rsp_t e;
    for (int op = 0; op < 9; op++) begin
      issue(1'b1, 4'(op), 16'hA5C3, 16'h0F31, 1'(op == 5), 1'(op == 4), ok);
      wait_rsp(got);
      n_tests++;
      if (!ok || !got || exp_q.size() == 0) begin
        n_fail++; $display("FAIL op%0d_rsp: ready=%0b rsp=%0b, want both", op, ok, got);
      end else begin
        e = exp_q.pop_front();
        if (act_rsp() !== e) begin n_fail++; $display("FAIL op%0d_rsp: got %h want %h", op, act_rsp(), e); end
      end
    end
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req0_half = 1'b0; bus.req0_byte = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.req1_half = 1'b0; bus.req1_byte = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_mult();
    test_illegal();
    test_reset_mid_exec();
    test_shl_half();
    test_all_ops();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
